// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package arm_ctrl_pkg;

  // Main FSM states; the 4-bit encoding leaves six illegal codes that recover to fetch.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  // Instr[27:26] major opcode.
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // ALUControl encodings.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // ALUSrcB selects.
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ResultSrc selects.
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // Data-processing cmd field, Instr[24:21].
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // True when a data-processing cmd must not write its destination register.
  function automatic logic cmd_nowrite(input logic [3:0] cmd);
    return !(cmd inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR});
  endfunction

endpackage

// File: rtl/mc_main_ctrl_if.sv
// Instruction fields in, datapath controls out, between the datapath and the control unit.
interface mc_main_ctrl_if;
  import arm_ctrl_pkg::*;

  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       MemRdy;

  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;
  logic [1:0] FlagW;
  logic       NextPC;
  logic       PCS;
  logic       RegW;
  logic       MemW;

  // Datapath side: supplies instruction fields and memory ready.
  modport master (
    output Op, Funct, Rd, MemRdy,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
    input  ALUControl, FlagW, NextPC, PCS, RegW, MemW
  );

  // Control unit side.
  modport slave (
    input  Op, Funct, Rd, MemRdy,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
    output ALUControl, FlagW, NextPC, PCS, RegW, MemW
  );

endinterface

// File: rtl/mc_alu_decoder.sv
// ALU operation / flag-write decode and PC-write request generation.
module mc_alu_decoder
  import arm_ctrl_pkg::*;
(
  input  logic       alu_op_i,
  input  logic [4:0] funct_i,       // {cmd, S}
  input  logic [3:0] rd_i,
  input  logic       reg_w_i,
  input  logic       branch_i,
  output logic [1:0] alu_control_o,
  output logic [1:0] flag_w_o,
  output logic       pcs_o,
  output logic       no_write_o
);

  logic [3:0] cmd;
  logic       s_bit;

  assign cmd   = funct_i[4:1];
  assign s_bit = funct_i[0];

  // Decode ALU operation, flag writes and NoWrite from the cmd field.
  always_comb begin
    alu_control_o = ALU_ADD;
    flag_w_o      = 2'b00;
    no_write_o    = 1'b0;
    if (alu_op_i) begin
      case (cmd)
        CMD_ADD: begin
          alu_control_o = ALU_ADD;
          flag_w_o      = s_bit ? 2'b11 : 2'b00;
        end
        CMD_SUB: begin
          alu_control_o = ALU_SUB;
          flag_w_o      = s_bit ? 2'b11 : 2'b00;
        end
        CMD_CMP: begin
          alu_control_o = ALU_SUB;
          flag_w_o      = s_bit ? 2'b11 : 2'b00;
          no_write_o    = 1'b1;
        end
        CMD_AND: begin
          alu_control_o = ALU_AND;
          flag_w_o      = s_bit ? 2'b10 : 2'b00;
        end
        CMD_ORR: begin
          alu_control_o = ALU_ORR;
          flag_w_o      = s_bit ? 2'b10 : 2'b00;
        end
        default: begin
          alu_control_o = ALU_ADD;
          flag_w_o      = 2'b00;
          no_write_o    = 1'b1;
        end
      endcase
    end
  end

  // A register write to R15 is a PC write; condlogic gates it with CondEx.
  assign pcs_o = branch_i | (reg_w_i & (rd_i == 4'hF));

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle ARM main controller: state register, next-state logic and Moore output table.
module mc_main_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input logic          clk,
  input logic          reset,        // active-low, asynchronous
  mc_main_ctrl_if.slave bus
);

  state_t     state_q, state_d;

  logic       ir_write;
  logic       adr_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       next_pc;
  logic       mem_w;
  logic       branch;
  logic       alu_op;
  logic       reg_w;
  logic       dec_no_write;
  logic       no_write;
  logic [1:0] alu_control;
  logic [1:0] flag_w;
  logic       pcs;

  // The only state in the block; reset drops any in-flight instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; MemRdy is only consulted in the three memory-access states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = bus.MemRdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          OP_DP:   state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = bus.MemRdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = bus.MemRdy ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state mux selects and enables.
  always_comb begin
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RD2;
    result_src = RES_ALUOUT;
    next_pc    = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        ir_write   = bus.MemRdy;
        next_pc    = bus.MemRdy;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
      end
      S_MEMADR:   alu_src_b = SRCB_IMM;
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB:    result_src = RES_DATA;
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      S_EXECUTER: alu_src_b = SRCB_RD2;
      S_EXECUTEI: alu_src_b = SRCB_IMM;
      S_ALUWB:    result_src = RES_ALUOUT;
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURES;
        branch     = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_op = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);

  // The decoder reports NoWrite only while ALUOp is high; ALUWB re-derives it from the
  // instruction register, which still holds the same Funct.
  assign no_write = alu_op ? dec_no_write : cmd_nowrite(bus.Funct[4:1]);

  // Kept as a separate assign so the PCS path through RegW is not a combinational loop.
  assign reg_w = (state_q == S_MEMWB) | ((state_q == S_ALUWB) & ~no_write);

  mc_alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct_i       (bus.Funct[4:0]),
    .rd_i          (bus.Rd),
    .reg_w_i       (reg_w),
    .branch_i      (branch),
    .alu_control_o (alu_control),
    .flag_w_o      (flag_w),
    .pcs_o         (pcs),
    .no_write_o    (dec_no_write)
  );

  assign bus.IRWrite    = ir_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == OP_BR, bus.Op == OP_MEM};
  assign bus.ALUControl = alu_control;
  assign bus.FlagW      = flag_w;
  assign bus.NextPC     = next_pc;
  assign bus.PCS        = pcs;
  assign bus.RegW       = reg_w;
  assign bus.MemW       = mem_w;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed, table-driven bench for the multicycle ARM main controller.
module tb_mc_main_ctrl;

  logic clk = 1'b0;
  logic reset;

  mc_main_ctrl_if bus ();

  mc_main_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One row per clock cycle: inputs applied, expected control word that cycle.
  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        rdy;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW, NextPC, PCS, RegW, MemW}
  function automatic logic [14:0] ev(bit irw, bit adr, bit srca, logic [1:0] srcb,
                                     logic [1:0] res, logic [1:0] aluc, logic [1:0] fw,
                                     bit npc, bit pcs, bit regw, bit memw);
    return {irw, adr, srca, srcb, res, aluc, fw, npc, pcs, regw, memw};
  endfunction

  logic [14:0] e_fetch1, e_fetch0, e_decode, e_memadr, e_memrd, e_memwb, e_memwr, e_branch;

  task automatic add(string name, logic [1:0] op, logic [5:0] funct, logic [3:0] rd,
                     logic rdy, logic [14:0] exp);
    vec_t v;
    v.name = name; v.op = op; v.funct = funct; v.rd = rd; v.rdy = rdy; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(logic [1:0] op, logic [5:0] funct, logic [3:0] rd, logic rdy);
    @(negedge clk);
    bus.Op = op; bus.Funct = funct; bus.Rd = rd; bus.MemRdy = rdy;
    #1;
  endtask

  // ImmSrc and RegSrc are derived from the applied Op, independent of state.
  task automatic check(string name, logic [14:0] exp);
    logic [18:0] act, req;
    act = {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl,
           bus.FlagW, bus.NextPC, bus.PCS, bus.RegW, bus.MemW, bus.ImmSrc, bus.RegSrc};
    req = {exp, bus.Op, (bus.Op == 2'b10), (bus.Op == 2'b01)};
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  initial begin
    e_fetch1 = ev(1, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 1, 0, 0, 0);
    e_fetch0 = ev(0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0);
    e_decode = e_fetch0;
    e_memadr = ev(0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    e_memrd  = ev(0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    e_memwb  = ev(0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 1, 0);
    e_memwr  = ev(0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1);
    e_branch = ev(0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0, 1, 0, 0);

    // ADDS R1,R2,#5
    add("adds_fetch", 2'b00, 6'b101001, 4'h1, 1, e_fetch1);
    add("adds_decode", 2'b00, 6'b101001, 4'h1, 0, e_decode);
    add("adds_exei", 2'b00, 6'b101001, 4'h1, 0, ev(0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0));
    add("adds_aluwb", 2'b00, 6'b101001, 4'h1, 0, ev(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0));
    // CMP R0,R1
    add("cmp_fetch", 2'b00, 6'b010101, 4'h0, 1, e_fetch1);
    add("cmp_decode", 2'b00, 6'b010101, 4'h0, 1, e_decode);
    add("cmp_exer", 2'b00, 6'b010101, 4'h0, 0, ev(0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b11, 0, 0, 0, 0));
    add("cmp_aluwb", 2'b00, 6'b010101, 4'h0, 0, 15'd0);
    // ORRS R2,R3,R4
    add("orrs_fetch", 2'b00, 6'b011001, 4'h2, 1, e_fetch1);
    add("orrs_decode", 2'b00, 6'b011001, 4'h2, 0, e_decode);
    add("orrs_exer", 2'b00, 6'b011001, 4'h2, 0, ev(0, 0, 0, 2'b00, 2'b00, 2'b11, 2'b10, 0, 0, 0, 0));
    add("orrs_aluwb", 2'b00, 6'b011001, 4'h2, 0, ev(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0));
    // AND R5,R6,R7 without S
    add("and_fetch", 2'b00, 6'b000000, 4'h5, 1, e_fetch1);
    add("and_decode", 2'b00, 6'b000000, 4'h5, 0, e_decode);
    add("and_exer", 2'b00, 6'b000000, 4'h5, 0, ev(0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0));
    add("and_aluwb", 2'b00, 6'b000000, 4'h5, 0, ev(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0));
    // Unsupported cmd 0001 with S: no flags, no write
    add("eors_fetch", 2'b00, 6'b000011, 4'h6, 1, e_fetch1);
    add("eors_decode", 2'b00, 6'b000011, 4'h6, 0, e_decode);
    add("eors_exer", 2'b00, 6'b000011, 4'h6, 0, 15'd0);
    add("eors_aluwb", 2'b00, 6'b000011, 4'h6, 0, 15'd0);
    // ADD PC,Rn,#imm: register write to R15 raises PCS
    add("addpc_fetch", 2'b00, 6'b101000, 4'hF, 1, e_fetch1);
    add("addpc_decode", 2'b00, 6'b101000, 4'hF, 0, e_decode);
    add("addpc_exei", 2'b00, 6'b101000, 4'hF, 0, ev(0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
    add("addpc_aluwb", 2'b00, 6'b101000, 4'hF, 0, ev(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1, 0));
    // LDR with a fetch stall and two read stalls
    add("ldr_fetch_stall", 2'b01, 6'b011001, 4'h3, 0, e_fetch0);
    add("ldr_fetch", 2'b01, 6'b011001, 4'h3, 1, e_fetch1);
    add("ldr_decode", 2'b01, 6'b011001, 4'h3, 0, e_decode);
    add("ldr_memadr", 2'b01, 6'b011001, 4'h3, 1, e_memadr);
    add("ldr_memrd_w1", 2'b01, 6'b011001, 4'h3, 0, e_memrd);
    add("ldr_memrd_w2", 2'b01, 6'b011001, 4'h3, 0, e_memrd);
    add("ldr_memrd_go", 2'b01, 6'b011001, 4'h3, 1, e_memrd);
    add("ldr_memwb", 2'b01, 6'b011001, 4'h3, 0, e_memwb);
    // STR with one write stall
    add("str_fetch", 2'b01, 6'b011000, 4'h4, 1, e_fetch1);
    add("str_decode", 2'b01, 6'b011000, 4'h4, 0, e_decode);
    add("str_memadr", 2'b01, 6'b011000, 4'h4, 0, e_memadr);
    add("str_memwr_w", 2'b01, 6'b011000, 4'h4, 0, e_memwr);
    add("str_memwr_go", 2'b01, 6'b011000, 4'h4, 1, e_memwr);
    // B
    add("b_fetch", 2'b10, 6'b101000, 4'h0, 1, e_fetch1);
    add("b_decode", 2'b10, 6'b101000, 4'h0, 0, e_decode);
    add("b_branch", 2'b10, 6'b101000, 4'h0, 1, e_branch);
    // Undefined Op=11 returns straight to fetch
    add("undef_fetch", 2'b11, 6'b000000, 4'hF, 1, e_fetch1);
    add("undef_decode", 2'b11, 6'b000000, 4'hF, 1, e_decode);
    add("undef_back", 2'b11, 6'b000000, 4'hF, 1, e_fetch1);
    add("undef_decode2", 2'b11, 6'b000000, 4'hF, 0, e_decode);
    add("undef_back2", 2'b11, 6'b000000, 4'hF, 0, e_fetch0);

    // Reset held low for 3 cycles with MemRdy low
    bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.MemRdy = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("reset_held", e_fetch0);
    reset = 1'b1;
    drive(2'b00, 6'd0, 4'd0, 0);
    check("post_reset_1", e_fetch0);
    drive(2'b00, 6'd0, 4'd0, 0);
    check("post_reset_2", e_fetch0);

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].funct, vecs[i].rd, vecs[i].rdy);
      check(vecs[i].name, vecs[i].exp);
    end

    // Reset pulse while waiting in MEMWRITE: MemW must drop without a clock edge
    drive(2'b01, 6'b011000, 4'h4, 1);
    check("rst_str_fetch", e_fetch1);
    drive(2'b01, 6'b011000, 4'h4, 0);
    drive(2'b01, 6'b011000, 4'h4, 0);
    drive(2'b01, 6'b011000, 4'h4, 0);
    check("rst_str_memwr", e_memwr);
    #1 reset = 1'b0;
    #1 check("rst_async_memw", e_fetch0);
    drive(2'b01, 6'b011000, 4'h4, 0);
    reset = 1'b1;
    check("rst_in_fetch", e_fetch0);
    drive(2'b00, 6'b101001, 4'h1, 1);
    check("rst_refetch", e_fetch1);

    // Reset during EXECUTEI drops the ALU writeback
    drive(2'b00, 6'b101001, 4'h1, 0);
    drive(2'b00, 6'b101001, 4'h1, 0);
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    drive(2'b00, 6'b101001, 4'h1, 0);
    check("rst_drop_aluwb", e_fetch0);
    drive(2'b00, 6'b101001, 4'h1, 1);
    check("rst_drop_refetch", e_fetch1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
